// File: rtl/tc_instr_fetch8_pkg.sv
// Shared widths and byte-lane helper for the instruction fetch stage.
package tc_instr_fetch8_pkg;

  localparam int PC_W            = 16;
  localparam int DATA_W          = 8;
  localparam int MAX_INSTR_BYTES = 8;

  // Bit offset of a byte lane inside the assembly buffer.
  function automatic int byte_lsb(input int lane);
    return lane * DATA_W;
  endfunction

endpackage

// File: rtl/tc_fetch_assembler.sv
// Collects returned memory bytes into one instruction word and captures the PC of byte 0.
// complete_o/word_o already include the byte arriving this cycle, so a full word can leave without a bubble.
module tc_fetch_assembler
  import tc_instr_fetch8_pkg::*;
#(
  parameter int INSTR_BYTES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          drain,
  input  logic                          rx_vld,
  input  logic [DATA_W-1:0]             rx_dat,
  input  logic [PC_W-1:0]               rx_pc,
  output logic [$clog2(INSTR_BYTES+1)-1:0] count_o,
  output logic                          complete_o,
  output logic [DATA_W*INSTR_BYTES-1:0] word_o,
  output logic [PC_W-1:0]               word_pc_o
);

  localparam int CNT_W = $clog2(INSTR_BYTES + 1);
  localparam int BUF_W = DATA_W * INSTR_BYTES;

  logic [CNT_W-1:0] count_q, count_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] fill;

  always_comb begin
    buf_d   = buf_q;
    pc_d    = pc_q;
    count_d = count_q;
    if (rx_vld) begin
      for (int i = 0; i < INSTR_BYTES; i++) begin
        if (count_q == CNT_W'(i)) buf_d[byte_lsb(i) +: DATA_W] = rx_dat;
      end
      if (count_q == '0) pc_d = rx_pc;
      count_d = count_q + CNT_W'(1);
    end
    // A drained or flushed buffer restarts at lane 0; stale lanes get overwritten.
    if (flush || drain) count_d = '0;
  end

  assign fill       = count_q + CNT_W'(rx_vld);
  assign complete_o = (fill == CNT_W'(INSTR_BYTES));
  assign word_o     = buf_d;
  assign word_pc_o  = pc_d;
  assign count_o    = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      buf_q   <= '0;
      pc_q    <= '0;
    end else begin
      count_q <= count_d;
      buf_q   <= buf_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: rtl/tc_instr_fetch8.sv
// Fetch stage: drives the byte-wide program memory address, assembles instructions, hands them out valid/ready.
// Issue stalls once buffered plus in-flight bytes fill an instruction and the output is blocked; jump flushes.
module tc_instr_fetch8
  import tc_instr_fetch8_pkg::*;
#(
  parameter int              INSTR_BYTES = 4,
  parameter logic [PC_W-1:0] RESET_PC    = 16'h0000
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [PC_W-1:0]               mem_address,
  input  logic [DATA_W-1:0]             mem_data,
  output logic [DATA_W*INSTR_BYTES-1:0] instr,
  output logic [PC_W-1:0]               instr_pc,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  input  logic                          jump,
  input  logic [PC_W-1:0]               jump_target
);

  localparam int CNT_W = $clog2(INSTR_BYTES + 1);
  localparam int BUF_W = DATA_W * INSTR_BYTES;

  logic [PC_W-1:0]  addr_q, addr_d;
  logic             inflight_q, inflight_d;
  logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic [BUF_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]  instr_pc_q, instr_pc_d;
  logic             instr_valid_q, instr_valid_d;

  logic [CNT_W-1:0] asm_count;
  logic             asm_complete;
  logic [BUF_W-1:0] asm_word;
  logic [PC_W-1:0]  asm_pc;
  logic             transfer;
  logic             issue;
  logic [CNT_W:0]   occ;

  tc_fetch_assembler #(.INSTR_BYTES(INSTR_BYTES)) u_asm (
    .clk        (clk),
    .rst        (rst),
    .flush      (jump),
    .drain      (transfer),
    .rx_vld     (inflight_q),
    .rx_dat     (mem_data),
    .rx_pc      (inflight_pc_q),
    .count_o    (asm_count),
    .complete_o (asm_complete),
    .word_o     (asm_word),
    .word_pc_o  (asm_pc)
  );

  always_comb begin
    transfer      = asm_complete && (!instr_valid_q || instr_ready) && !jump;
    // Occupancy counts the byte arriving now; a transfer this cycle empties the buffer.
    occ           = transfer ? '0 : ({1'b0, asm_count} + (CNT_W+1)'(inflight_q));
    issue         = (occ < (CNT_W+1)'(INSTR_BYTES));

    addr_d        = addr_q;
    inflight_d    = issue;
    inflight_pc_d = addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q && !instr_ready;

    if (transfer) begin
      instr_d       = asm_word;
      instr_pc_d    = asm_pc;
      instr_valid_d = 1'b1;
    end
    if (issue) addr_d = addr_q + PC_W'(1);

    // A handshake in the jump cycle has already completed; only later state is discarded.
    if (jump) begin
      addr_d        = jump_target;
      inflight_d    = 1'b0;
      instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign mem_address = addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_tc_instr_fetch8.sv
// Scoreboarded bench: expected instruction stream derived from memory contents, PC arithmetic and jumps.
module tb_tc_instr_fetch8;

  localparam int N = 4;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   mem_address;
  logic [7:0]    mem_data;
  logic [8*N-1:0] instr;
  logic [15:0]   instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          jump;
  logic [15:0]   jump_target;

  tc_instr_fetch8 #(.INSTR_BYTES(N), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump        (jump),
    .jump_target (jump_target)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  logic [15:0] addr_s;

  // Program memory: address seen in cycle c returns data throughout cycle c+1.
  always @(negedge clk) addr_s = mem_address;
  always @(posedge clk) begin
    #1;
    mem_data = mem[addr_s];
  end

  int checks = 0;
  int failures = 0;
  int hs_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8*N-1:0] word_at(input logic [15:0] pc);
    logic [8*N-1:0] w;
    logic [15:0] a;
    w = '0;
    for (int b = 0; b < N; b++) begin
      a = pc + 16'(b);
      w[b*8 +: 8] = mem[a];
    end
    return w;
  endfunction

  typedef struct {
    logic [15:0]    pc;
    logic [8*N-1:0] w;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] tail_pc;

  task automatic push_next();
    exp_t e;
    e.pc = tail_pc;
    e.w  = word_at(tail_pc);
    exp_q.push_back(e);
    tail_pc = tail_pc + 16'(N);
  endtask

  task automatic refill(input logic [15:0] pc);
    exp_q.delete();
    tail_pc = pc;
    for (int i = 0; i < 8; i++) push_next();
  endtask

  // Monitor: pops on every accepted instruction, checks hold stability, then applies jump/reset to the model.
  logic           hold_prev = 1'b0;
  logic [8*N-1:0] prev_instr;
  logic [15:0]    prev_pc;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (hold_prev) begin
        check("hold_valid", 64'(instr_valid), 64'd1);
        check("hold_instr", 64'(instr), 64'(prev_instr));
        check("hold_pc", 64'(instr_pc), 64'(prev_pc));
      end
      if (instr_valid && instr_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty actual_pc=%0h expected=none", instr_pc);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", 64'(instr_pc), 64'(e.pc));
          check("sb_instr", 64'(instr), 64'(e.w));
          push_next();
        end
      end
      hold_prev  = instr_valid && !instr_ready && !jump;
      prev_instr = instr;
      prev_pc    = instr_pc;
      if (jump) refill(jump_target);
    end else begin
      hold_prev = 1'b0;
      refill(RST_PC);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!instr_valid && k < 50) begin
      next_cycle();
      k++;
    end
  endtask

  task automatic jump_to(input logic [15:0] t, output int lat);
    int k;
    jump = 1'b1;
    jump_target = t;
    next_cycle();
    jump = 1'b0;
    check("jump_addr", 64'(mem_address), 64'(t));
    wait_valid(k);
    lat = k + 1;
  endtask

  initial begin
    int k;
    int lat;
    int hs0;
    logic [15:0] t;
    rst = 1'b1;
    instr_ready = 1'b1;
    jump = 1'b0;
    jump_target = '0;
    mem_data = '0;
    addr_s = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

    // Reset release and first instruction timing.
    do_reset();
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_pc", 64'(instr_pc), 64'd0);
    check("rst_addr", 64'(mem_address), 64'(RST_PC));
    wait_valid(k);
    check("first_valid_cycle", 64'(k), 64'd5);
    check("first_instr", 64'(instr), 64'h44332211);
    check("first_pc", 64'(instr_pc), 64'h0000);
    repeat (4) next_cycle();
    check("second_valid", 64'(instr_valid), 64'd1);
    check("second_pc", 64'(instr_pc), 64'h0004);

    // Backpressure for ten cycles after first valid.
    instr_ready = 1'b0;
    do_reset();
    wait_valid(k);
    check("bp_first_cycle", 64'(k), 64'd5);
    repeat (9) next_cycle();
    check("bp_addr_stop", 64'(mem_address), 64'h0008);
    check("bp_held_pc", 64'(instr_pc), 64'h0000);
    next_cycle();
    instr_ready = 1'b1;
    next_cycle();
    check("bp_release_valid", 64'(instr_valid), 64'd1);
    check("bp_release_pc", 64'(instr_pc), 64'h0004);

    // Jump mid-assembly with two bytes received.
    do_reset();
    repeat (3) next_cycle();
    jump_to(16'h0040, lat);
    check("mid_jump_latency", 64'(lat), 64'd6);
    check("mid_jump_pc", 64'(instr_pc), 64'h0040);

    // Wrap-around across 16'hFFFF.
    jump_to(16'hFFFE, lat);
    check("wrap_latency", 64'(lat), 64'd6);
    check("wrap_pc", 64'(instr_pc), 64'hFFFE);
    check("wrap_instr", 64'(instr), 64'(word_at(16'hFFFE)));
    repeat (4) next_cycle();
    check("wrap_next_pc", 64'(instr_pc), 64'h0002);

    // Jump coincident with a completing handshake.
    check("coinc_pre_valid", 64'(instr_valid), 64'd1);
    hs0 = hs_count;
    jump_to(16'h1234, lat);
    check("coinc_accepted", 64'(hs_count - hs0), 64'd1);
    check("coinc_latency", 64'(lat), 64'd6);
    check("coinc_pc", 64'(instr_pc), 64'h1234);

    // Reset while output is held and assembly is in progress.
    instr_ready = 1'b0;
    do_reset();
    wait_valid(k);
    repeat (2) next_cycle();
    rst = 1'b1;
    next_cycle();
    check("rst_hold_valid", 64'(instr_valid), 64'd0);
    check("rst_hold_addr", 64'(mem_address), 64'(RST_PC));
    rst = 1'b0;
    instr_ready = 1'b1;
    wait_valid(k);
    check("rst_hold_restart_cycle", 64'(k), 64'd5);
    check("rst_hold_restart_instr", 64'(instr), 64'h44332211);

    // Randomised ready/jump traffic, checked by the scoreboard.
    hs0 = hs_count;
    for (int c = 0; c < 1500; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      jump = ($urandom_range(0, 29) == 0);
      t = 16'($urandom);
      if ($urandom_range(0, 3) == 0) t = 16'hFFFC + 16'($urandom_range(0, 3));
      jump_target = t;
      next_cycle();
    end
    jump = 1'b0;
    check("random_progress", 64'(hs_count - hs0 > 100), 64'd1);

    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
